feature_cache_reader: RTL and testbench
=======================================

# feature_cache_reader

Read-side client of the feature cache: accepts a burst request (base address, length), drives the cache's read-address port one word per cycle, absorbs the cache's one-cycle read latency, and presents the words as a valid/ready stream with a last marker. It sits between the feature cache's read port and any downstream consumer (classifier/compare stages) that needs contiguous feature words with backpressure.

## Interface
Parameters are the pkg_featureCache constants, not module parameters:
- ADDR_WIDTH, pkg value: cache address width.
- WORD_SIZE, pkg value: cache word width.
- WORDS, pkg value: cache depth; need not be a power of two.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  burst request present.
- req_ready  out  1  high only in IDLE.
- req_base  in  ADDR_WIDTH  first word address, < WORDS.
- req_len  in  ADDR_WIDTH+1  word count; 0 allowed.
- fcr_in  out  structs::struct_featureCache_Read_In  .raddr to cache.
- fcr_out  in  structs::struct_featureCache_Read_Out  .q from cache.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_data  out  WORD_SIZE  feature word.
- out_last  out  1  final word of burst, qualified by out_valid.
- busy  out  1  state != IDLE.

## Operation
- FSM: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on handshake with req_len > 0: latch addr = req_base, issue_cnt = req_len, pop_cnt = req_len.
  - Handshake with req_len = 0 completes with no reads and no output; the FSM stays in IDLE.
  - FETCH: issue a read, with raddr = addr, when there is room.
    - Room means: fifo_occ + inflight - pop < 2, where pop = out_valid && out_ready.
    - On issue: decrement issue_cnt. Advance addr, with WORDS-1 wrapping to 0.
    - FETCH -> DRAIN after the issue that takes issue_cnt to 0.
  - DRAIN -> IDLE on the pop that takes pop_cnt to 0.
- Cache returns q the cycle after raddr is presented.
  - A one-bit inflight flag marks that q is valid.
  - If inflight is set, q is written into a 2-entry FIFO in that cycle.
  - The cache is read unconditionally. Without the flag, q is ignored.
- fcr_in.raddr = addr register. It holds its value when not issuing.
- out_last = out_valid && pop_cnt == 1.
- AXI-style rules apply to the output:
  - out_data and out_last are stable while out_valid && !out_ready.
  - out_valid does not depend combinationally on out_ready.
- req_len > WORDS is legal: addresses keep wrapping modulo WORDS.
- No protection against concurrent cache writes. The caller must not write addresses inside an active burst, because mixed-port read-during-write is undefined.
- Reset values:
  - Outputs: req_ready 1, fcr_in.raddr 0, out_valid 0, out_data 0, out_last 0, busy 0.
  - Internal state: IDLE, FIFO empty, inflight 0.
- Reset asserted mid-burst:
  - Everything clears immediately, asynchronously.
  - In-flight and buffered words are discarded.
  - No out_last is emitted.

## Timing
- Handshake in cycle T. raddr = base in T+1. First out_valid in T+3.
- Sustained throughput is 1 word/cycle when out_ready is held high.
- A len-N burst with no backpressure:
  - Reads in T+1..T+N.
  - Output in T+3..T+N+2.
  - req_ready high again in T+N+3.
- Backpressure: at most 2 words are buffered plus 0 in flight, so issue stalls within one cycle of out_ready falling.
- req_valid held high while busy is not accepted until IDLE. Back-to-back bursts are separated by one IDLE cycle.

## Structure
- pkg_featureCache:
  - Add READER_FIFO_DEPTH = 2.
  - Add typedef reader_state_t {IDLE, FETCH, DRAIN}.
- structs package: add struct_featureCacheReader_Req {base, len} for upstream use.
- One sub-module: fcr_skid_fifo, a 2-entry register FIFO with push, pop, occ, head data, and async active-low reset.

## Test plan
Setup: WORDS=16, WORD_SIZE=8, cache preloaded with mem[i] = 0x10+i.
- base 3, len 4, out_ready=1:
  - raddr 3,4,5,6 in T+1..T+4.
  - out_data 0x13..0x16 in T+3..T+6, out_last only with 0x16.
  - req_ready=1 in T+7.
- Wrap: base 14, len 4 → output 0x1E, 0x1F, 0x10, 0x11, then out_last. raddr sequence 14, 15, 0, 1.
- Backpressure: base 0, len 8, out_ready low for 5 cycles from the first out_valid:
  - 0x10 is held stable. Exactly 2 words are buffered and raddr stops advancing.
  - On release, all 8 words arrive in order with no loss or duplication.
- len 0 → no raddr activity, out_valid stays 0, busy stays 0, req_ready stays 1.
- Reset after 2 of 6 words popped:
  - out_valid and busy drop to 0 immediately.
  - A following request with base 5, len 1 returns only 0x15, with out_last.
- req_valid held high across a burst with base 2, len 2:
  - The second request is accepted only in the first IDLE cycle after 0x13 pops.
  - No outputs overlap between the two bursts.

Source files
------------

// File: rtl/feature_cache_reader_pkg.sv
// Shared constants, state encoding and cache-port structs for the feature
// cache read client.
package feature_cache_reader_pkg;

   // Cache geometry; WORDS need not be a power of two.
   localparam int ADDR_WIDTH        = 4;
   localparam int WORD_SIZE         = 8;
   localparam int WORDS             = 16;
   localparam int LEN_WIDTH         = ADDR_WIDTH + 1;

   // Output buffering between the cache and the consumer.
   localparam int READER_FIFO_DEPTH = 2;
   localparam int OCC_WIDTH         = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } reader_state_t;

   // Read-address side of the cache port.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] raddr;
   } struct_featureCache_Read_In;

   // Read-data side of the cache port, valid one cycle after raddr.
   typedef struct packed {
      logic [WORD_SIZE-1:0] q;
   } struct_featureCache_Read_Out;

   // Burst request bundle for upstream clients.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] base;
      logic [LEN_WIDTH-1:0]  len;
   } struct_featureCacheReader_Req;

   // Next cache address, wrapping at the last word rather than at 2**ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] nxt;
      if (addr == ADDR_WIDTH'(WORDS - 1)) begin
         nxt = {ADDR_WIDTH{1'b0}};
      end else begin
         nxt = addr + ADDR_WIDTH'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/feature_cache_reader_if.sv
// Request handshake and output stream of the feature cache reader.
interface feature_cache_reader_if;
   import feature_cache_reader_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_base;
   logic [LEN_WIDTH-1:0]  req_len;

   logic                  out_valid;
   logic                  out_ready;
   logic [WORD_SIZE-1:0]  out_data;
   logic                  out_last;

   // Reader side: accepts requests, produces the word stream.
   modport slave (
      input  req_valid, req_base, req_len, out_ready,
      output req_ready, out_valid, out_data, out_last
   );

   // Client side: issues requests, consumes the word stream.
   modport master (
      output req_valid, req_base, req_len, out_ready,
      input  req_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/feature_cache_reader_skid_fifo.sv
// Two-entry register FIFO that absorbs the cache read latency so the output
// stream can stall without losing the word already in flight.
module fcr_skid_fifo
   import feature_cache_reader_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push_i,
   input  logic [WORD_SIZE-1:0] push_data_i,
   input  logic                 pop_i,
   output logic [OCC_WIDTH-1:0] occ_o,
   output logic [WORD_SIZE-1:0] head_o
);

   logic [WORD_SIZE-1:0] ent0_q, ent0_d;
   logic [WORD_SIZE-1:0] ent1_q, ent1_d;
   logic [OCC_WIDTH-1:0] occ_q, occ_d;

   // Entry 0 is always the head; a pop shifts entry 1 down.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      occ_d  = occ_q;
      case ({push_i, pop_i})
         2'b10: begin
            case (occ_q)
               2'd0: begin
                  ent0_d = push_data_i;
                  occ_d  = 2'd1;
               end
               2'd1: begin
                  ent1_d = push_data_i;
                  occ_d  = 2'd2;
               end
               default: begin
                  occ_d = occ_q;
               end
            endcase
         end
         2'b01: begin
            case (occ_q)
               2'd1: begin
                  occ_d = 2'd0;
               end
               2'd2: begin
                  ent0_d = ent1_q;
                  occ_d  = 2'd1;
               end
               default: begin
                  occ_d = occ_q;
               end
            endcase
         end
         2'b11: begin
            case (occ_q)
               2'd0: begin
                  ent0_d = push_data_i;
                  occ_d  = 2'd1;
               end
               2'd1: begin
                  ent0_d = push_data_i;
                  occ_d  = 2'd1;
               end
               2'd2: begin
                  ent0_d = ent1_q;
                  ent1_d = push_data_i;
                  occ_d  = 2'd2;
               end
               default: begin
                  occ_d = occ_q;
               end
            endcase
         end
         default: begin
            occ_d = occ_q;
         end
      endcase
   end

   // Storage and occupancy registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q <= {WORD_SIZE{1'b0}};
         ent1_q <= {WORD_SIZE{1'b0}};
         occ_q  <= {OCC_WIDTH{1'b0}};
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         occ_q  <= occ_d;
      end
   end

   assign occ_o  = occ_q;
   assign head_o = ent0_q;

endmodule

// File: rtl/feature_cache_reader.sv
// Burst read client of the feature cache: walks the read port one word per
// cycle and presents the returned words as a valid/ready stream with last.
module feature_cache_reader
   import feature_cache_reader_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   feature_cache_reader_if.slave       bus,
   output struct_featureCache_Read_In  fcr_in,
   input  struct_featureCache_Read_Out fcr_out,
   output logic                        busy
);

   reader_state_t         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
   logic [LEN_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
   logic                  inflight_q, inflight_d;

   logic [OCC_WIDTH-1:0]  fifo_occ_s;
   logic [WORD_SIZE-1:0]  fifo_head_s;
   logic                  out_valid_s;
   logic                  pop_s;
   logic                  issue_s;
   logic                  room_s;
   logic                  req_hs_s;

   assign out_valid_s = (fifo_occ_s != {OCC_WIDTH{1'b0}});
   assign pop_s       = out_valid_s && bus.out_ready;
   assign req_hs_s    = bus.req_valid && (state_q == IDLE);

   // Words already buffered or about to land, net of this cycle's pop, must
   // leave a slot free so an issued read can never overflow the FIFO.
   assign room_s = (({1'b0, fifo_occ_s} + {2'b00, inflight_q})
                    < (3'(READER_FIFO_DEPTH) + {2'b00, pop_s}));

   // Next-state logic: request capture, read issue and burst completion.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      issue_cnt_d = issue_cnt_q;
      pop_cnt_d   = pop_cnt_q;
      issue_s     = 1'b0;

      if (pop_s) begin
         pop_cnt_d = pop_cnt_q - LEN_WIDTH'(1);
      end else begin
         pop_cnt_d = pop_cnt_q;
      end

      case (state_q)
         IDLE: begin
            if (req_hs_s && (bus.req_len != {LEN_WIDTH{1'b0}})) begin
               state_d     = FETCH;
               addr_d      = bus.req_base;
               issue_cnt_d = bus.req_len;
               pop_cnt_d   = bus.req_len;
            end else begin
               // A zero-length request completes here with no reads.
               state_d = IDLE;
            end
         end
         FETCH: begin
            if (room_s) begin
               issue_s     = 1'b1;
               addr_d      = next_addr(addr_q);
               issue_cnt_d = issue_cnt_q - LEN_WIDTH'(1);
               if (issue_cnt_q == LEN_WIDTH'(1)) begin
                  state_d = DRAIN;
               end else begin
                  state_d = FETCH;
               end
            end else begin
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (pop_s && (pop_cnt_q == LEN_WIDTH'(1))) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      inflight_d = issue_s;
   end

   // Burst control registers; reset discards any in-flight read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         issue_cnt_q <= {LEN_WIDTH{1'b0}};
         pop_cnt_q   <= {LEN_WIDTH{1'b0}};
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         issue_cnt_q <= issue_cnt_d;
         pop_cnt_q   <= pop_cnt_d;
         inflight_q  <= inflight_d;
      end
   end

   // Cache data is only meaningful the cycle after an issued read.
   fcr_skid_fifo u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_data_i (fcr_out.q),
      .pop_i       (pop_s),
      .occ_o       (fifo_occ_s),
      .head_o      (fifo_head_s)
   );

   assign fcr_in.raddr  = addr_q;
   assign bus.req_ready = (state_q == IDLE);
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = fifo_head_s;
   assign bus.out_last  = out_valid_s && (pop_cnt_q == LEN_WIDTH'(1));
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_feature_cache_reader.sv
// Directed bench for feature_cache_reader against a 16-word cache model
// preloaded with mem[i] = 0x10 + i.
module tb_feature_cache_reader;
   import feature_cache_reader_pkg::*;

   logic clk;
   logic rst_n;
   logic busy;
   struct_featureCache_Read_In  fcr_in;
   struct_featureCache_Read_Out fcr_out;
   logic [7:0] mem [16];

   int errors = 0;
   int checks = 0;

   feature_cache_reader_if bus ();

   feature_cache_reader dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .fcr_in  (fcr_in),
      .fcr_out (fcr_out),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One-cycle-latency cache read port
   always @(posedge clk) begin
      fcr_out.q <= mem[fcr_in.raddr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Unstalled burst issued in the current (IDLE) cycle T; checks T+1..T+len+3.
   task automatic run_burst(input int base, input int len);
      bus.req_valid = 1'b1;
      bus.req_base  = 4'(base);
      bus.req_len   = 5'(len);
      chk("burst_req_ready_T", 32'(bus.req_ready), 32'd1);
      for (int k = 1; k <= len + 3; k++) begin
         step();
         bus.req_valid = 1'b0;
         if (k <= len) chk("burst_raddr", 32'(fcr_in.raddr), 32'((base + k - 1) % 16));
         chk("burst_out_valid", 32'(bus.out_valid), 32'(k >= 3 && k <= len + 2));
         if (k >= 3 && k <= len + 2) begin
            chk("burst_out_data", 32'(bus.out_data), 32'(8'h10 + ((base + k - 3) % 16)));
            chk("burst_out_last", 32'(bus.out_last), 32'(k == len + 2));
         end
         chk("burst_req_ready", 32'(bus.req_ready), 32'(k == len + 3));
         chk("burst_busy", 32'(busy), 32'(k <= len + 2));
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'(8'h10 + i);
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_base  = 4'd0;
      bus.req_len   = 5'd0;
      bus.out_ready = 1'b1;
      step();
      step();

      // Reset values
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_raddr",     32'(fcr_in.raddr),  32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data",  32'(bus.out_data),  32'd0);
      chk("rst_out_last",  32'(bus.out_last),  32'd0);
      chk("rst_busy",      32'(busy),          32'd0);
      rst_n = 1'b1;
      step();

      // Basic burst: base 3, len 4 -> 0x13..0x16
      run_burst(3, 4);

      // Address wrap: base 14, len 4 -> 0x1E,0x1F,0x10,0x11
      run_burst(14, 4);

      // Zero-length request: no activity, raddr stays at 2 from the wrap burst
      bus.req_valid = 1'b1;
      bus.req_base  = 4'd7;
      bus.req_len   = 5'd0;
      chk("len0_req_ready_T", 32'(bus.req_ready), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         step();
         bus.req_valid = 1'b0;
         chk("len0_busy",      32'(busy),          32'd0);
         chk("len0_req_ready", 32'(bus.req_ready), 32'd1);
         chk("len0_out_valid", 32'(bus.out_valid), 32'd0);
         chk("len0_raddr",     32'(fcr_in.raddr),  32'd2);
      end

      // Backpressure: base 0, len 8, out_ready low for T+3..T+7
      bus.req_valid = 1'b1;
      bus.req_base  = 4'd0;
      bus.req_len   = 5'd8;
      for (int k = 1; k <= 16; k++) begin
         step();
         bus.req_valid = 1'b0;
         bus.out_ready = (k >= 3 && k <= 7) ? 1'b0 : 1'b1;
         if (k >= 3 && k <= 7) begin
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_data",  32'(bus.out_data),  32'h10);
            chk("bp_hold_last",  32'(bus.out_last),  32'd0);
            chk("bp_hold_raddr", 32'(fcr_in.raddr),  32'd2);
         end
         if (k >= 4 && k <= 7) chk("bp_occ", 32'(dut.fifo_occ_s), 32'd2);
         if (k >= 8 && k <= 15) begin
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_out_data",  32'(bus.out_data),  32'(8'h10 + (k - 8)));
            chk("bp_out_last",  32'(bus.out_last),  32'(k == 15));
         end
         if (k == 16) begin
            chk("bp_end_valid", 32'(bus.out_valid), 32'd0);
            chk("bp_end_ready", 32'(bus.req_ready), 32'd1);
         end
      end

      // Reset after two of six words popped
      bus.req_valid = 1'b1;
      bus.req_base  = 4'd0;
      bus.req_len   = 5'd6;
      for (int k = 1; k <= 5; k++) begin
         step();
         bus.req_valid = 1'b0;
         if (k == 3) chk("mid_w0", 32'(bus.out_data), 32'h10);
         if (k == 4) chk("mid_w1", 32'(bus.out_data), 32'h11);
      end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_busy",      32'(busy),          32'd0);
      chk("mid_rst_out_last",  32'(bus.out_last),  32'd0);
      chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
      step();
      rst_n = 1'b1;
      run_burst(5, 1);

      // req_valid held high: second acceptance only at T+5, outputs T+3,4 and T+8,9
      bus.req_valid = 1'b1;
      bus.req_base  = 4'd2;
      bus.req_len   = 5'd2;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 6) bus.req_valid = 1'b0;
         chk("hold_req_ready", 32'(bus.req_ready), 32'(k == 5 || k == 10));
         chk("hold_out_valid", 32'(bus.out_valid), 32'(k == 3 || k == 4 || k == 8 || k == 9));
         if (k == 3 || k == 8) chk("hold_data_a", 32'(bus.out_data), 32'h12);
         if (k == 4 || k == 9) begin
            chk("hold_data_b", 32'(bus.out_data), 32'h13);
            chk("hold_last",   32'(bus.out_last), 32'd1);
         end
         if (k == 6) chk("hold_raddr2", 32'(fcr_in.raddr), 32'd2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
